// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: valid/ready load channel carrying four hex digits plus decimal points.
interface seg_scan_ctrl_if;
    logic valid;
    logic ready;
    logic [15:0] data;
    logic [3:0] dp;
    modport master(output valid, data, dp, input ready);
    modport slave(input valid, data, dp, output ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scan scheduler with blanking dead-time, hex decode,
// leading-zero suppression and frame-synchronous display value updates.
module seg_scan_ctrl #(
    parameter int SCAN_CYCLES = 100_000,
    parameter int BLANK_CYCLES = 1_000,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    seg_scan_ctrl_if.slave load,
    output logic [3:0] sel,
    output logic [7:0] seg,
    output logic frame_tick
);
    localparam int MAXC = SCAN_CYCLES > BLANK_CYCLES ? SCAN_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t state, state_n;
    logic [1:0] idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0] act_data, act_data_n, pend_data;
    logic [3:0] act_dp, act_dp_n, pend_dp;
    logic pend_full, xfer, commit;
    logic [3:0] digit, zero;
    logic [6:0] glyph;

    assign load.ready = !pend_full;
    assign xfer = load.valid && !pend_full;
    // Only a value already buffered before this cycle may commit, so capture and commit never coincide.
    assign commit = pend_full && (state == IDLE || (enable && state == SHOW && idx == 2'd3 && cnt == SCAN_LAST));
    assign act_data_n = commit ? pend_data : act_data;
    assign act_dp_n = commit ? pend_dp : act_dp;
    assign digit = act_data_n[{idx_n, 2'b00} +: 4];
    assign zero = {act_data_n[15:12] == 4'h0, act_data_n[15:8] == 8'h00, act_data_n[15:4] == 12'h000, 1'b0};
    assign glyph = (LZ_BLANK && zero[idx_n]) ? 7'h00 : HEX[digit];

    always_comb begin
        state_n = state;
        idx_n = idx;
        cnt_n = cnt + 1'b1;
        if (!enable) begin
            state_n = IDLE;
            idx_n = '0;
            cnt_n = '0;
        end else if (state == IDLE) begin
            state_n = BLANK_CYCLES == 0 ? SHOW : BLANK;
            cnt_n = '0;
        end else if (state == BLANK && cnt == BLANK_LAST) begin
            state_n = SHOW;
            cnt_n = '0;
        end else if (state == SHOW && cnt == SCAN_LAST) begin
            state_n = BLANK_CYCLES == 0 ? SHOW : BLANK;
            idx_n = idx + 2'd1;
            cnt_n = '0;
        end
    end

    // Outputs are built from next-cycle values so sel and seg switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            act_data <= '0;
            act_dp <= '0;
            pend_data <= '0;
            pend_dp <= '0;
            pend_full <= 1'b0;
            sel <= '0;
            seg <= '0;
            frame_tick <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            cnt <= cnt_n;
            act_data <= act_data_n;
            act_dp <= act_dp_n;
            pend_full <= xfer || (pend_full && !commit);
            if (xfer) begin
                pend_data <= load.data;
                pend_dp <= load.dp;
            end
            sel <= state_n == SHOW ? 4'b0001 << idx_n : 4'b0000;
            seg <= state_n == SHOW ? {act_dp_n[idx_n], glyph} : 8'h00;
            frame_tick <= state_n == SHOW && idx_n == 2'd3 && cnt_n == SCAN_LAST;
        end
    end
endmodule
